router_fsm: RTL and testbench
=============================

# router_fsm

Packet-sequencing controller for the router's input path. Decodes the destination field of each header byte, waits for the target output FIFO to drain, then steps the register stage and FIFO write path through header, payload, full-stall and parity phases. Drives the phase strobes consumed by the register/parity block and the FIFO write enable, and accepts its parity and low-valid status back. Sits between the packet source and the register stage, alongside the FIFO-select synchronizer.

## Interface
- NUM_PORTS, 3: number of output FIFOs; legal destination addresses are 0..NUM_PORTS-1.
- ADDR_W, 2: width of the address field, data_in[ADDR_W-1:0].
- TIMEOUT_CYCLES, 1024: wait-state limit; used only when the timeout feature is compiled in.

Ports, clock and reset first:
- clk  in  1  clock, all logic on the rising edge.
- reset  in  1  one clock; reset is synchronous and active-high.
- pkt_valid  in  1  source has a valid packet byte; its fall marks the parity byte.
- data_in  in  ADDR_W  address field of the current byte; sampled only in DECODE_ADDRESS.
- fifo_full  in  1  full flag of the currently selected FIFO.
- fifo_empty  in  NUM_PORTS  per-FIFO empty flags.
- soft_reset  in  NUM_PORTS  per-FIFO abort, raised when a FIFO's read side times out.
- parity_done  in  1  from the register stage.
- low_pkt_valid  in  1  from the register stage.
- detect_add  out  1  high in DECODE_ADDRESS.
- lfd_state  out  1  high in LOAD_FIRST_DATA.
- ld_state  out  1  high in LOAD_DATA.
- laf_state  out  1  high in LOAD_AFTER_FULL.
- full_state  out  1  high in FIFO_FULL_STATE.
- rst_int_reg  out  1  high in CHECK_PARITY_ERROR.
- write_enb_reg  out  1  high in LOAD_DATA, LOAD_PARITY and LOAD_AFTER_FULL.
- busy  out  1  high in every state except DECODE_ADDRESS and LOAD_DATA.
- dest_addr  out  ADDR_W  latched destination address.
- timeout  out  1  one-cycle abort pulse; tied 0 when the feature is compiled out.

## Operation
- State register, one-hot or binary, 8 states. All outputs are decoded from the state register only (Moore), except timeout.
- DECODE_ADDRESS: when pkt_valid is high and data_in is below NUM_PORTS, latch dest_addr <= data_in. If fifo_empty[data_in] is high, go to LOAD_FIRST_DATA; otherwise go to WAIT_TILL_EMPTY. An out-of-range address (3 when NUM_PORTS=3) or pkt_valid low keeps the FSM in DECODE_ADDRESS, and the packet is dropped.
- WAIT_TILL_EMPTY: go to LOAD_FIRST_DATA when fifo_empty[dest_addr] is high.
- LOAD_FIRST_DATA: go to LOAD_DATA unconditionally.
- LOAD_DATA: if fifo_full, go to FIFO_FULL_STATE. Else if pkt_valid is low, go to LOAD_PARITY. Else stay. fifo_full has priority over the pkt_valid fall.
- FIFO_FULL_STATE: go to LOAD_AFTER_FULL when fifo_full is low.
- LOAD_AFTER_FULL: if parity_done, go to DECODE_ADDRESS. Else if low_pkt_valid, go to LOAD_PARITY. Else go to LOAD_DATA.
- LOAD_PARITY: go to CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: if fifo_full, go to FIFO_FULL_STATE; otherwise go to DECODE_ADDRESS.
- Priority, highest first: reset, then soft_reset[dest_addr] (any state except DECODE_ADDRESS goes to DECODE_ADDRESS), then timeout, then the normal transitions.
- soft_reset bits for non-selected ports are ignored.

## Timing
- Reset: state = DECODE_ADDRESS, dest_addr = 0, timeout counter = 0.
- After reset: detect_add = 1. All other strobes, busy and timeout = 0.
- Strobes change in the cycle after the edge that moves the state; there is no extra pipeline.
- Header byte is accepted at the edge that leaves DECODE_ADDRESS. lfd_state is high on the next cycle.
- Minimum packet with an empty target FIFO: DECODE, LFD, LD, LP, CPE, DECODE, i.e. 5 cycles of state.
- Reset asserted mid-packet wins that edge; no strobe carries over.

## Configuration
- ROUTER_FSM_TIMEOUT_EN defined:
  - Counter of width $clog2(TIMEOUT_CYCLES+1) counts while in WAIT_TILL_EMPTY or FIFO_FULL_STATE.
  - Counter clears on any other state and on reset.
  - On reaching TIMEOUT_CYCLES-1 while still waiting: next state is DECODE_ADDRESS and timeout pulses for 1 cycle, registered and coincident with the return to DECODE_ADDRESS.
- ROUTER_FSM_TIMEOUT_EN undefined: no counter; timeout is tied 0; the wait states can last indefinitely.

## Structure
- Shared package router_pkg holds:
  - State enum router_fsm_state_t.
  - Default NUM_PORTS and ADDR_W.
  - Localparam for the invalid address value.
- Optional sub-module router_fsm_timer (counter plus expiry compare), instantiated only under ROUTER_FSM_TIMEOUT_EN.

## Test plan
- Reset, then pkt_valid=1, data_in=2'b01, fifo_empty=3'b111 -> next cycle lfd_state=1, dest_addr=1; then ld_state=1 with write_enb_reg=1, busy=0.
- data_in=2'b10, fifo_empty=3'b011 -> WAIT_TILL_EMPTY, busy=1; raise fifo_empty[2] -> lfd_state next cycle.
- Addr 0, 4 payload bytes, pkt_valid falls -> LOAD_PARITY (write_enb_reg=1), then rst_int_reg=1 for exactly 1 cycle, then detect_add=1.
- fifo_full=1 in LOAD_DATA -> full_state=1 until fifo_full=0; then laf_state=1; with low_pkt_valid=1 and parity_done=0 -> LOAD_PARITY.
- Waiting on addr 1, pulse soft_reset=3'b010 -> detect_add=1 next cycle; soft_reset=3'b100 instead -> no effect.
- Compiled with ROUTER_FSM_TIMEOUT_EN, TIMEOUT_CYCLES=8, fifo_empty held 0 -> timeout=1 exactly 8 cycles after entering WAIT_TILL_EMPTY, FSM in DECODE_ADDRESS.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and defaults for the router input-path controller.
package router_pkg;

   localparam int DEFAULT_NUM_PORTS = 3;
   localparam int DEFAULT_ADDR_W    = 2;

   // First address with no FIFO behind it; headers carrying it are dropped.
   localparam logic [DEFAULT_ADDR_W-1:0] ADDR_INVALID = DEFAULT_ADDR_W'(DEFAULT_NUM_PORTS);

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      WAIT_TILL_EMPTY    = 3'd1,
      LOAD_FIRST_DATA    = 3'd2,
      LOAD_DATA          = 3'd3,
      FIFO_FULL_STATE    = 3'd4,
      LOAD_AFTER_FULL    = 3'd5,
      LOAD_PARITY        = 3'd6,
      CHECK_PARITY_ERROR = 3'd7
   } router_fsm_state_t;

endpackage

// File: rtl/router_fsm_timer.sv
// Wait-state watchdog: counts cycles while count_en_i is high, clears otherwise.
// expired_o is combinational, high on the last allowed waiting cycle.
module router_fsm_timer #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic count_en_i,
   output logic expired_o
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = '0;
      if (count_en_i) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = count_en_i && (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/router_fsm.sv
// Packet-sequencing FSM: Moore phase strobes one cycle after each state change; waits for FIFO drain/unfull.
// Optional wait-state watchdog compiled in with ROUTER_FSM_TIMEOUT_EN.
module router_fsm
   import router_pkg::*;
#(
   parameter int NUM_PORTS      = DEFAULT_NUM_PORTS,
   parameter int ADDR_W         = DEFAULT_ADDR_W,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pkt_valid,
   input  logic [ADDR_W-1:0]    data_in,
   input  logic                 fifo_full,
   input  logic [NUM_PORTS-1:0] fifo_empty,
   input  logic [NUM_PORTS-1:0] soft_reset,
   input  logic                 parity_done,
   input  logic                 low_pkt_valid,
   output logic                 detect_add,
   output logic                 lfd_state,
   output logic                 ld_state,
   output logic                 laf_state,
   output logic                 full_state,
   output logic                 rst_int_reg,
   output logic                 write_enb_reg,
   output logic                 busy,
   output logic [ADDR_W-1:0]    dest_addr,
   output logic                 timeout
);

   router_fsm_state_t state_q, state_d;
   logic [ADDR_W-1:0] dest_addr_q, dest_addr_d;
   logic              addr_in_range;
   logic              empty_new;
   logic              empty_sel;
   logic              soft_reset_sel;
   logic              tmo_expired;
   logic              timeout_d;

   // Per-port selects done by compare so any ADDR_W/NUM_PORTS pairing stays in range.
   always_comb begin
      addr_in_range  = 1'b0;
      empty_new      = 1'b0;
      empty_sel      = 1'b0;
      soft_reset_sel = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (data_in == ADDR_W'(i)) begin
            addr_in_range = 1'b1;
            empty_new     = fifo_empty[i];
         end
         if (dest_addr_q == ADDR_W'(i)) begin
            empty_sel      = fifo_empty[i];
            soft_reset_sel = soft_reset[i];
         end
      end
   end

`ifdef ROUTER_FSM_TIMEOUT_EN
   logic timeout_q;

   router_fsm_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .count_en_i ((state_q == WAIT_TILL_EMPTY) || (state_q == FIFO_FULL_STATE)),
      .expired_o  (tmo_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign tmo_expired = 1'b0;
   // Constant 0 for every legal configuration; keeps the parameter referenced.
   assign timeout     = (TIMEOUT_CYCLES < 0);
`endif

   always_comb begin
      state_d     = state_q;
      dest_addr_d = dest_addr_q;
      timeout_d   = 1'b0;

      unique case (state_q)
         DECODE_ADDRESS: begin
            if (pkt_valid && addr_in_range) begin
               dest_addr_d = data_in;
               state_d     = empty_new ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
         end
         WAIT_TILL_EMPTY: begin
            if (empty_sel) state_d = LOAD_FIRST_DATA;
         end
         LOAD_FIRST_DATA: state_d = LOAD_DATA;
         LOAD_DATA: begin
            if (fifo_full)       state_d = FIFO_FULL_STATE;
            else if (!pkt_valid) state_d = LOAD_PARITY;
         end
         FIFO_FULL_STATE: begin
            if (!fifo_full) state_d = LOAD_AFTER_FULL;
         end
         LOAD_AFTER_FULL: begin
            if (parity_done)        state_d = DECODE_ADDRESS;
            else if (low_pkt_valid) state_d = LOAD_PARITY;
            else                    state_d = LOAD_DATA;
         end
         LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
         CHECK_PARITY_ERROR: begin
            state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
         end
         default: state_d = DECODE_ADDRESS;
      endcase

      // Abort of the selected FIFO outranks the watchdog, which outranks normal flow.
      if ((state_q != DECODE_ADDRESS) && soft_reset_sel) begin
         state_d = DECODE_ADDRESS;
      end else if (tmo_expired) begin
         state_d   = DECODE_ADDRESS;
         timeout_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= DECODE_ADDRESS;
         dest_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         dest_addr_q <= dest_addr_d;
      end
   end

   assign detect_add    = (state_q == DECODE_ADDRESS);
   assign lfd_state     = (state_q == LOAD_FIRST_DATA);
   assign ld_state      = (state_q == LOAD_DATA);
   assign laf_state     = (state_q == LOAD_AFTER_FULL);
   assign full_state    = (state_q == FIFO_FULL_STATE);
   assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
   assign write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                          (state_q == LOAD_AFTER_FULL);
   assign busy          = (state_q != DECODE_ADDRESS) && (state_q != LOAD_DATA);
   assign dest_addr     = dest_addr_q;

endmodule

// File: tb/tb_router_fsm.sv
// Directed-vector bench for router_fsm; strobe vector order is
// {detect_add, lfd, ld, laf, full, rst_int_reg, write_enb_reg, busy}.
module tb_router_fsm;
   import router_pkg::*;

   localparam int NP = 3;
   localparam int AW = 2;

   localparam logic [7:0] S_DEC  = 8'h80;
   localparam logic [7:0] S_WAIT = 8'h01;
   localparam logic [7:0] S_LFD  = 8'h41;
   localparam logic [7:0] S_LD   = 8'h22;
   localparam logic [7:0] S_LAF  = 8'h13;
   localparam logic [7:0] S_FULL = 8'h09;
   localparam logic [7:0] S_LP   = 8'h03;
   localparam logic [7:0] S_CPE  = 8'h05;

   logic          clk = 1'b0;
   logic          reset;
   logic          pkt_valid;
   logic [AW-1:0] data_in;
   logic          fifo_full;
   logic [NP-1:0] fifo_empty;
   logic [NP-1:0] soft_reset;
   logic          parity_done;
   logic          low_pkt_valid;
   logic          detect_add, lfd_state, ld_state, laf_state, full_state;
   logic          rst_int_reg, write_enb_reg, busy, timeout;
   logic [AW-1:0] dest_addr;

   int n_cmp = 0;
   int n_bad = 0;

   router_fsm #(
      .NUM_PORTS      (NP),
      .ADDR_W         (AW),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .pkt_valid     (pkt_valid),
      .data_in       (data_in),
      .fifo_full     (fifo_full),
      .fifo_empty    (fifo_empty),
      .soft_reset    (soft_reset),
      .parity_done   (parity_done),
      .low_pkt_valid (low_pkt_valid),
      .detect_add    (detect_add),
      .lfd_state     (lfd_state),
      .ld_state      (ld_state),
      .laf_state     (laf_state),
      .full_state    (full_state),
      .rst_int_reg   (rst_int_reg),
      .write_enb_reg (write_enb_reg),
      .busy          (busy),
      .dest_addr     (dest_addr),
      .timeout       (timeout)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs set afterwards land 1 time unit past the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_st(input string tag, input logic [7:0] strobes, input logic [AW-1:0] dest);
      check_eq({tag, ".strobes"}, 32'({detect_add, lfd_state, ld_state, laf_state,
                                       full_state, rst_int_reg, write_enb_reg, busy}), 32'(strobes));
      check_eq({tag, ".dest"}, 32'(dest_addr), 32'(dest));
   endtask

   initial begin
      logic [AW-1:0] bad_addr;
      bad_addr      = ADDR_INVALID;
      reset         = 1'b1;
      pkt_valid     = 1'b0;
      data_in       = '0;
      fifo_full     = 1'b0;
      fifo_empty    = 3'b111;
      soft_reset    = 3'b000;
      parity_done   = 1'b0;
      low_pkt_valid = 1'b0;
      step(); step();
      reset = 1'b0;
      expect_st("reset", S_DEC, 2'd0);
      check_eq("reset.timeout", 32'(timeout), 32'd0);

      // Empty target: DECODE -> LFD -> LD -> LP -> CPE -> DECODE
      pkt_valid = 1'b1; data_in = 2'b01;
      step(); expect_st("p1.lfd", S_LFD, 2'd1);
      step(); expect_st("p1.ld", S_LD, 2'd1);
      pkt_valid = 1'b0;
      step(); expect_st("p1.lp", S_LP, 2'd1);
      step(); expect_st("p1.cpe", S_CPE, 2'd1);
      step(); expect_st("p1.dec", S_DEC, 2'd1);

      // Target not empty: wait for fifo_empty[2]
      pkt_valid = 1'b1; data_in = 2'b10; fifo_empty = 3'b011;
      step(); expect_st("p2.wait", S_WAIT, 2'd2);
      pkt_valid = 1'b0;
      step(); expect_st("p2.wait2", S_WAIT, 2'd2);
      fifo_empty = 3'b111;
      step(); expect_st("p2.lfd", S_LFD, 2'd2);
      step(); expect_st("p2.ld", S_LD, 2'd2);
      step(); expect_st("p2.lp", S_LP, 2'd2);
      step(); expect_st("p2.cpe", S_CPE, 2'd2);
      step(); expect_st("p2.dec", S_DEC, 2'd2);

      // Address 0 with four payload bytes
      pkt_valid = 1'b1; data_in = 2'b00;
      step(); expect_st("p3.lfd", S_LFD, 2'd0);
      for (int i = 0; i < 4; i++) begin
         step(); expect_st("p3.ld", S_LD, 2'd0);
      end
      pkt_valid = 1'b0;
      step(); expect_st("p3.lp", S_LP, 2'd0);
      step(); expect_st("p3.cpe", S_CPE, 2'd0);
      step(); expect_st("p3.dec", S_DEC, 2'd0);

      // Out-of-range header is dropped, dest_addr untouched
      pkt_valid = 1'b1; data_in = bad_addr;
      step(); expect_st("badaddr", S_DEC, 2'd0);
      step(); expect_st("badaddr2", S_DEC, 2'd0);
      pkt_valid = 1'b0;

      // fifo_full beats pkt_valid fall in LD; LAF with low_pkt_valid -> LP
      pkt_valid = 1'b1; data_in = 2'b01;
      step(); expect_st("p4.lfd", S_LFD, 2'd1);
      step(); expect_st("p4.ld", S_LD, 2'd1);
      fifo_full = 1'b1; pkt_valid = 1'b0;
      step(); expect_st("p4.full", S_FULL, 2'd1);
      step(); expect_st("p4.full2", S_FULL, 2'd1);
      fifo_full = 1'b0;
      step(); expect_st("p4.laf", S_LAF, 2'd1);
      low_pkt_valid = 1'b1;
      step(); expect_st("p4.lp", S_LP, 2'd1);
      low_pkt_valid = 1'b0;
      step(); expect_st("p4.cpe", S_CPE, 2'd1);
      step(); expect_st("p4.dec", S_DEC, 2'd1);

      // LAF -> LD, CPE with full -> FULL, LAF with parity_done -> DECODE
      pkt_valid = 1'b1; data_in = 2'b10;
      step(); expect_st("p5.lfd", S_LFD, 2'd2);
      fifo_full = 1'b1;
      step(); expect_st("p5.ld", S_LD, 2'd2);
      step(); expect_st("p5.full", S_FULL, 2'd2);
      fifo_full = 1'b0;
      step(); expect_st("p5.laf", S_LAF, 2'd2);
      step(); expect_st("p5.ld2", S_LD, 2'd2);
      pkt_valid = 1'b0;
      step(); expect_st("p5.lp", S_LP, 2'd2);
      fifo_full = 1'b1;
      step(); expect_st("p5.cpe", S_CPE, 2'd2);
      step(); expect_st("p5.full2", S_FULL, 2'd2);
      fifo_full = 1'b0;
      step(); expect_st("p5.laf2", S_LAF, 2'd2);
      parity_done = 1'b1;
      step(); expect_st("p5.dec", S_DEC, 2'd2);
      parity_done = 1'b0;

      // soft_reset: only the selected port's bit aborts
      pkt_valid = 1'b1; data_in = 2'b01; fifo_empty = 3'b000;
      step(); expect_st("sr.wait", S_WAIT, 2'd1);
      pkt_valid = 1'b0; soft_reset = 3'b100;
      step(); expect_st("sr.other", S_WAIT, 2'd1);
      soft_reset = 3'b010;
      step(); expect_st("sr.abort", S_DEC, 2'd1);
      soft_reset = 3'b000; fifo_empty = 3'b111;

      // Reset mid-packet
      pkt_valid = 1'b1; data_in = 2'b10;
      step(); expect_st("mr.lfd", S_LFD, 2'd2);
      step(); expect_st("mr.ld", S_LD, 2'd2);
      reset = 1'b1; pkt_valid = 1'b0;
      step(); expect_st("mr.reset", S_DEC, 2'd0);
      reset = 1'b0;
      step(); expect_st("mr.idle", S_DEC, 2'd0);

`ifdef ROUTER_FSM_TIMEOUT_EN
      // Watchdog: pulse lands 8 cycles after entering WAIT
      pkt_valid = 1'b1; data_in = 2'b00; fifo_empty = 3'b000;
      step(); expect_st("to.wait0", S_WAIT, 2'd0);
      pkt_valid = 1'b0;
      for (int k = 1; k < 8; k++) begin
         step();
         expect_st("to.wait", S_WAIT, 2'd0);
         check_eq("to.quiet", 32'(timeout), 32'd0);
      end
      step(); expect_st("to.dec", S_DEC, 2'd0);
      check_eq("to.pulse", 32'(timeout), 32'd1);
      step(); check_eq("to.pulse_end", 32'(timeout), 32'd0);
      expect_st("to.idle", S_DEC, 2'd0);
      fifo_empty = 3'b111;
`else
      // No watchdog: waiting persists well past 8 cycles
      pkt_valid = 1'b1; data_in = 2'b00; fifo_empty = 3'b000;
      step(); expect_st("nt.wait0", S_WAIT, 2'd0);
      pkt_valid = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         check_eq("nt.timeout", 32'(timeout), 32'd0);
      end
      expect_st("nt.wait", S_WAIT, 2'd0);
      fifo_empty = 3'b001;
      step(); expect_st("nt.lfd", S_LFD, 2'd0);
      fifo_empty = 3'b111;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
